eq_band_mixer: RTL and testbench

//   Downstream of the per-band biquad filters in the equalizer. Combines the

---
 rtl/eq_band_mixer.sv | 173 +++++++++++++++++
 tb/tb_eq_band_mixer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_mixer.sv
// eq_band_mixer
//   Combines the outputs of the equalizer's per-band biquad filters into one
//   output sample. Each band sample is scaled by its signed fixed-point gain.
//   One multiplier is time-shared across the bands, one band per clock. The
//   products are summed into a wide accumulator, then shifted right by GFRAC
//   and saturated to W bits.
//
//   State table
//     state  | meaning
//     S_IDLE | waiting for sample_tick; the shadow registers are loaded on the tick
//     S_MAC  | accumulating one band product per clock (idx = band)
//     S_OUT  | rescales and saturates acc into mix_y, pulses mix_valid
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   sample_tick  one-cycle pulse: band_y holds a new set of samples
//   band_y       NBANDS packed signed samples, band i at [i*W +: W]
//   band_gain    NBANDS packed signed gains Q(W-GFRAC).GFRAC, band i at [i*W +: W]
//   band_en      per-band enable; a disabled band contributes 0
//   mix_y        registered, saturated mix result
//   mix_valid    one-cycle pulse when mix_y updates
//   busy         high while a mix is in progress
//   sat          the last mix_y was clipped
//   overrun      sticky flag: a sample_tick arrived while busy and was dropped
module eq_band_mixer #(
    parameter int NBANDS = 4,
    parameter int W      = 18,
    parameter int GFRAC  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic [NBANDS*W-1:0]   band_y,
    input  logic [NBANDS*W-1:0]   band_gain,
    input  logic [NBANDS-1:0]     band_en,
    output logic [W-1:0]          mix_y,
    output logic                  mix_valid,
    output logic                  busy,
    output logic                  sat,
    output logic                  overrun
);

    localparam int IW = (NBANDS > 1) ? $clog2(NBANDS) : 1;
    // The accumulator is wide enough that the sum of NBANDS full-scale
    // products cannot overflow.
    localparam int AW = 2*W + IW + 1;

    localparam logic signed [AW-1:0] R_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] R_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [IW-1:0]        IDX_LAST = IW'(NBANDS-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IW-1:0]          idx;
    logic signed [W-1:0]    y_shd [NBANDS];
    logic signed [W-1:0]    g_shd [NBANDS];
    logic [NBANDS-1:0]      en_shd;
    logic signed [AW-1:0]   acc;

    logic signed [W-1:0]    y_cur;
    logic signed [W-1:0]    g_cur;
    logic signed [2*W-1:0]  prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   r;

    // Shared multiplier: operands come from the shadow copy selected by idx.
    assign y_cur    = y_shd[idx];
    assign g_cur    = g_shd[idx];
    assign prod     = y_cur * g_cur;
    assign prod_ext = en_shd[idx] ? {{(AW-2*W){prod[2*W-1]}}, prod} : '0;

    // Arithmetic shift gives floor rounding of the rescaled sum.
    assign r = acc >>> GFRAC;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (sample_tick) begin
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (idx == IDX_LAST) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            acc       <= '0;
            en_shd    <= '0;
            mix_y     <= '0;
            mix_valid <= 1'b0;
            sat       <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NBANDS; i++) begin
                y_shd[i] <= '0;
                g_shd[i] <= '0;
            end
        end else begin
            mix_valid <= 1'b0;

            // A tick that arrives mid-mix is dropped; the running mix is untouched.
            if (sample_tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (sample_tick) begin
                        for (int i = 0; i < NBANDS; i++) begin
                            y_shd[i] <= band_y[i*W +: W];
                            g_shd[i] <= band_gain[i*W +: W];
                        end
                        en_shd <= band_en;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                S_MAC: begin
                    acc <= acc + prod_ext;
                    if (idx != IDX_LAST) begin
                        idx <= idx + 1'b1;
                    end
                end
                S_OUT: begin
                    mix_valid <= 1'b1;
                    if (r > R_MAX) begin
                        mix_y <= R_MAX[W-1:0];
                        sat   <= 1'b1;
                    end else if (r < R_MIN) begin
                        mix_y <= R_MIN[W-1:0];
                        sat   <= 1'b1;
                    end else begin
                        mix_y <= r[W-1:0];
                        sat   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
module tb_eq_band_mixer;

    localparam int NB = 4;
    localparam int W  = 18;
    localparam int GF = 14;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sample_tick = 1'b0;
    logic [NB*W-1:0] band_y = '0;
    logic [NB*W-1:0] band_gain = '0;
    logic [NB-1:0]   band_en = '0;
    logic [W-1:0]    mix_y;
    logic            mix_valid;
    logic            busy;
    logic            sat;
    logic            overrun;

    int errors = 0;
    int checks = 0;

    int  cur_y [NB];
    int  cur_g [NB];
    logic [NB-1:0] cur_en;

    eq_band_mixer #(.NBANDS(NB), .W(W), .GFRAC(GF)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .band_y      (band_y),
        .band_gain   (band_gain),
        .band_en     (band_en),
        .mix_y       (mix_y),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .sat         (sat),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact signed sum of enabled products, floor-divided by 2^GF,
    // then clipped to the W-bit signed range.
    task automatic model(output int exp_y, output int exp_s);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < NB; i++) begin
            if (cur_en[i]) acc += longint'(cur_y[i]) * longint'(cur_g[i]);
        end
        r = acc >>> GF;
        exp_s = 0;
        if (r > 131071) begin
            r = 131071; exp_s = 1;
        end else if (r < -131072) begin
            r = -131072; exp_s = 1;
        end
        exp_y = int'(r);
    endtask

    task automatic drive();
        for (int i = 0; i < NB; i++) begin
            band_y[i*W +: W]    = cur_y[i][W-1:0];
            band_gain[i*W +: W] = cur_g[i][W-1:0];
        end
        band_en = cur_en;
    endtask

    task automatic scramble();
        band_y    = {$urandom, $urandom, $urandom};
        band_gain = {$urandom, $urandom, $urandom};
        band_en   = 4'($urandom);
    endtask

    task automatic set_all(input int y, input int g, input logic [NB-1:0] en);
        for (int i = 0; i < NB; i++) begin
            cur_y[i] = y;
            cur_g[i] = g;
        end
        cur_en = en;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mix_y"}, int'(mix_y), 0);
        check({tag, "_mix_valid"}, int'(mix_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_sat"}, int'(sat), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // Called #1 after a rising edge. Issues one tick and follows the mix
    // through edges 1..NB+3, checking timing, busy and the result.
    task automatic run_mix(input string tag);
        int ey, es;
        model(ey, es);
        drive();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        scramble();
        check({tag, "_busy_e1"}, int'(busy), 1);
        check({tag, "_valid_e1"}, int'(mix_valid), 0);
        for (int e = 2; e <= NB + 1; e++) begin
            @(posedge clk); #1;
            check($sformatf("%s_valid_e%0d", tag, e), int'(mix_valid), 0);
        end
        @(posedge clk); #1;
        check({tag, "_valid_out"}, int'(mix_valid), 1);
        check({tag, "_mix_y"}, int'($signed(mix_y)), ey);
        check({tag, "_sat"}, int'(sat), es);
        check({tag, "_busy_out"}, int'(busy), 0);
        @(posedge clk); #1;
        check({tag, "_valid_after"}, int'(mix_valid), 0);
        check({tag, "_mix_y_hold"}, int'($signed(mix_y)), ey);
        check({tag, "_sat_hold"}, int'(sat), es);
    endtask

    initial begin
        int ey, es;
        int seen_valid;

        // 1. reset
        #12;
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("post_reset");

        // 2. unity gains, all bands on
        cur_y = '{1000, 2000, -500, 3};
        cur_g = '{16384, 16384, 16384, 16384};
        cur_en = 4'hF;
        run_mix("basic");
        check("basic_const", int'($signed(mix_y)), 2503);

        // 3. saturation both ways
        set_all(100000, 16384, 4'hF);
        run_mix("sat_pos");
        check("sat_pos_const", int'($signed(mix_y)), 131071);
        set_all(-100000, 16384, 4'hF);
        run_mix("sat_neg");
        check("sat_neg_const", int'($signed(mix_y)), -131072);

        // 4. band enables
        cur_y = '{10, 20, 30, 40};
        cur_g = '{16384, 16384, 16384, 16384};
        cur_en = 4'b0101;
        run_mix("enable");
        check("enable_const", int'($signed(mix_y)), 40);

        // 5. floor rounding of a negative half
        cur_y = '{-3, 0, 0, 0};
        cur_g = '{8192, 0, 0, 0};
        cur_en = 4'hF;
        run_mix("floor");
        check("floor_const", int'($signed(mix_y)), -2);

        // all bands disabled
        set_all(77777, 30000, 4'h0);
        run_mix("all_off");

        // randomized mixes
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NB; i++) begin
                cur_y[i] = int'($urandom_range(0, 262143)) - 131072;
                cur_g[i] = (n % 2 == 0) ? int'($urandom_range(0, 262143)) - 131072
                                         : int'($urandom_range(0, 32768)) - 16384;
            end
            cur_en = 4'($urandom);
            run_mix($sformatf("rand%0d", n));
        end

        // 6a. tick two cycles into a mix is dropped
        cur_y = '{111, 222, 333, 444};
        cur_g = '{16384, 8192, 4096, 16384};
        cur_en = 4'hF;
        model(ey, es);
        drive();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NB; i++) cur_y[i] = -5000;
        drive();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        check("ovr_flag", int'(overrun), 1);
        seen_valid = 0;
        for (int e = 4; e <= 12 && seen_valid == 0; e++) begin
            @(posedge clk); #1;
            if (mix_valid) seen_valid = e;
        end
        check("ovr_valid_edge", seen_valid, NB + 2);
        check("ovr_mix_y", int'($signed(mix_y)), ey);
        repeat (2) @(posedge clk);
        #1;
        check("ovr_no_second_mix", int'(busy), 0);
        check("ovr_sticky", int'(overrun), 1);

        // 6b. reset during MAC aborts the mix
        cur_y = '{5000, 5000, 5000, 5000};
        cur_g = '{16384, 16384, 16384, 16384};
        drive();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        #2;
        rst = 1'b0;
        seen_valid = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (mix_valid || busy) seen_valid = 1;
        end
        check("abort_no_valid", seen_valid, 0);
        check("abort_mix_y", int'(mix_y), 0);

        // recovery after abort
        cur_y = '{-7, 9, 1234, -4321};
        cur_g = '{-16384, 32768, 12000, 9000};
        cur_en = 4'b1011;
        run_mix("recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
